// File: rtl/memory_rw_be.sv
// Byte-addressed read/write memory with start/ready handshake, per-byte write enables,
// a selectable access delay and a combinational peek port.
module memory_rw_be #(
   parameter int SIZE          = 256,
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_BYTES    = 4,
   parameter int DELAY_MODE    = 0,
   parameter int FIXED_DELAY   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      rwn,
   input  logic [ADDRESS_WIDTH-1:0]  address,
   input  logic [8*DATA_BYTES-1:0]   data_in,
   input  logic [DATA_BYTES-1:0]     byte_en,
   output logic [8*DATA_BYTES-1:0]   data_out,
   output logic                      ready,
   output logic                      done,
   input  logic [ADDRESS_WIDTH-1:0]  a_adr,
   output logic [8*DATA_BYTES-1:0]   a_data
);

   // state  | meaning
   // S_IDLE | waiting for start, ready=1
   // S_BUSY | request latched, counting down wait cycles, access on counter==0

   localparam int         IW      = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [7:0] FIXED_D = 8'(FIXED_DELAY);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t                    state, state_nxt;
   logic [7:0]                cnt;
   logic [7:0]                delay_val;
   logic                      rwn_q;
   logic [ADDRESS_WIDTH-1:0]  adr_q;
   logic [8*DATA_BYTES-1:0]   din_q;
   logic [DATA_BYTES-1:0]     be_q;
   logic                      accept;
   logic                      access;
   logic [7:0]                mem [SIZE];

   // Base address is reduced modulo SIZE first so lane offsets never carry elsewhere.
   function automatic logic [IW-1:0] lane_idx(input logic [ADDRESS_WIDTH-1:0] a,
                                               input int unsigned lane);
      int unsigned base;
      base = 32'(a) % SIZE;
      return IW'((base + lane) % SIZE);
   endfunction

   assign delay_val = (DELAY_MODE == 1) ? FIXED_D : {6'd0, address[1:0]};
   assign accept    = ready && start;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start)       state_nxt = S_BUSY;
         S_BUSY:  if (cnt == 8'd0) state_nxt = S_IDLE;
         default:                  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ready  = 1'b0;
      access = 1'b0;
      case (state)
         S_IDLE:  ready  = 1'b1;
         S_BUSY:  access = (cnt == 8'd0);
         default: ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= 8'd0;
         rwn_q <= 1'b0;
         adr_q <= '0;
         din_q <= '0;
         be_q  <= '0;
         done  <= 1'b0;
      end else begin
         done <= access;
         if (accept) begin
            cnt   <= delay_val;
            rwn_q <= rwn;
            adr_q <= address;
            din_q <= data_in;
            be_q  <= byte_en;
         end else if (state == S_BUSY && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < SIZE; j++) mem[j] <= 8'd0;
      end else if (access && !rwn_q) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            if (be_q[i]) mem[lane_idx(adr_q, i)] <= din_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out <= '0;
      end else if (access && rwn_q) begin
         for (int i = 0; i < DATA_BYTES; i++) data_out[8*i +: 8] <= mem[lane_idx(adr_q, i)];
      end
   end

   always_comb begin
      a_data = '0;
      for (int i = 0; i < DATA_BYTES; i++) a_data[8*i +: 8] = mem[lane_idx(a_adr, i)];
   end

endmodule
